mem_bus_ctrl: RTL

Multi-cycle data-bus controller for the MEM stage. It takes one load or store per instruction from the MEM stage and runs it as a single Wishbone-style classic cycle on the data bus. While the access is outstanding it stalls the pipeline, then returns read data for exactly one cycle. It sits between the MEM stage and the data RAM/bus fabric, and its stall request feeds the pipeline stall controller.

---
 rtl/mem_bus_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/mem_bus_ctrl.sv
// MEM-stage data-bus controller: runs one load/store per instruction as a classic
// Wishbone cycle, stalls the pipeline while it is outstanding, and pulses done_o on completion.
module mem_bus_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  sel_i,
  input  logic        flush_i,
  output logic        stallreq_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        bus_cyc_o,
  output logic        bus_stb_o,
  output logic        bus_we_o,
  output logic [31:0] bus_adr_o,
  output logic [31:0] bus_dat_o,
  output logic [3:0]  bus_sel_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_dat_i
);

  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, BUSY, DONE, DRAIN} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             tmo_hit;

  // A zero TIMEOUT means the slave is trusted to ack eventually.
  assign tmo_hit = (TIMEOUT != 0) && (cnt == CNT_LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      done_o    <= 1'b0;
      rdata_o   <= '0;
      err_o     <= 1'b0;
      bus_cyc_o <= 1'b0;
      bus_stb_o <= 1'b0;
      bus_we_o  <= 1'b0;
      bus_adr_o <= '0;
      bus_dat_o <= '0;
      bus_sel_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_i && !flush_i) begin
            bus_we_o  <= we_i;
            bus_adr_o <= addr_i;
            bus_dat_o <= wdata_i;
            bus_sel_o <= sel_i;
            bus_cyc_o <= 1'b1;
            bus_stb_o <= 1'b1;
            cnt       <= '0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != '1) cnt <= cnt + CNT_W'(1);
          if (flush_i) begin
            state <= DRAIN;
          end else if (bus_ack_i) begin
            rdata_o   <= bus_we_o ? 32'd0 : bus_dat_i;
            done_o    <= 1'b1;
            err_o     <= 1'b0;
            bus_cyc_o <= 1'b0;
            bus_stb_o <= 1'b0;
            state     <= DONE;
          end else if (tmo_hit) begin
            rdata_o   <= '0;
            done_o    <= 1'b1;
            err_o     <= 1'b1;
            bus_cyc_o <= 1'b0;
            bus_stb_o <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: begin
          done_o <= 1'b0;
          err_o  <= 1'b0;
          state  <= IDLE;
        end
        DRAIN: begin
          // Cancelled access still runs to its ack so the slave is never cut off.
          if (cnt != '1) cnt <= cnt + CNT_W'(1);
          if (bus_ack_i || tmo_hit) begin
            bus_cyc_o <= 1'b0;
            bus_stb_o <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    stallreq_o = 1'b0;
    case (state)
      IDLE:    stallreq_o = req_i & ~flush_i;
      BUSY:    stallreq_o = 1'b1;
      DONE:    stallreq_o = 1'b0;
      DRAIN:   stallreq_o = req_i;
      default: stallreq_o = 1'b0;
    endcase
  end

endmodule
